// File: rtl/sprite_palette_lut_pkg.sv
// Shared types and default-palette helpers for the sprite palette lookup.
// COLOR_W is fixed here because rgb_t is built from it.
package sprite_pkg;

    localparam int COLOR_W = 4;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Magenta: the colour that renders as "no pixel".
    function automatic rgb_t key_rgb();
        rgb_t k;
        k.r = '1;
        k.g = '0;
        k.b = '1;
        return k;
    endfunction

    // Index 0 is transparent; every other index is a grey ramp scaled to full range.
    function automatic rgb_t default_entry(input logic [COLOR_W-1:0] idx, input int idx_w);
        rgb_t               e;
        logic [COLOR_W-1:0] g;
        g = idx << (COLOR_W - idx_w);
        if (idx == '0) e = key_rgb();
        else           e = '{g, g, g};
        return e;
    endfunction

endpackage

// File: rtl/sprite_palette_lut_ram.sv
// Simple dual-port palette RAM: one synchronous write port, one registered
// read port, write-first when both ports hit the same address.
module sprite_palette_ram #(
    parameter int DEPTH = 192,
    parameter int AW    = 8,
    parameter int DW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-palette colour lookup: self-loading defaults, runtime write port,
// 2-stage read pipeline with transparency detect. Optional highlight: SPRITE_PALETTE_HIGHLIGHT_EN.
module sprite_palette_lut
    import sprite_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int NUM_PAL = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pix_valid,
    input  logic [$clog2(NUM_PAL)-1:0] pix_pal,
    input  logic [IDX_W-1:0]           pix_idx,
    input  logic                       pix_hl,
    input  logic                       wr_en,
    input  logic [$clog2(NUM_PAL)-1:0] wr_pal,
    input  logic [IDX_W-1:0]           wr_idx,
    input  logic [3*COLOR_W-1:0]       wr_rgb,
    output logic                       init_done,
    output logic                       out_valid,
    output logic [COLOR_W-1:0]         red,
    output logic [COLOR_W-1:0]         green,
    output logic [COLOR_W-1:0]         blue,
    output logic                       transparent
);

    localparam int PAL_W  = $clog2(NUM_PAL);
    localparam int AW     = PAL_W + IDX_W;
    localparam int DEPTH  = NUM_PAL << IDX_W;
    localparam int STAGES = 2;
    localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);
    localparam logic [PAL_W:0]   PAL_LIM = (PAL_W + 1)'(NUM_PAL);
    localparam logic [COLOR_W-1:0] CMAX  = '1;

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic          init_wr, run;

    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            INIT:    if (cnt == LAST) state_nx = RUN;
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        init_wr = (state == INIT);
        run     = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset)        cnt <= '0;
        else if (init_wr) cnt <= cnt + 1'b1;
    end

    assign init_done = run;

    // Linear counter order equals {pal, idx}, so INIT walks palette-major.
    logic          wr_ok, pix_ok, ram_we;
    logic [AW-1:0] ram_waddr, ram_raddr;
    rgb_t          ram_wdata, rdata;

    always_comb begin
        wr_ok     = {1'b0, wr_pal}  < PAL_LIM;
        pix_ok    = {1'b0, pix_pal} < PAL_LIM;
        ram_we    = init_wr | (run & wr_en & wr_ok);
        ram_waddr = init_wr ? cnt : {wr_pal, wr_idx};
        ram_wdata = init_wr ? default_entry(COLOR_W'(cnt[IDX_W-1:0]), IDX_W) : rgb_t'(wr_rgb);
        ram_raddr = pix_ok ? {pix_pal, pix_idx} : '0;
    end

    sprite_palette_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (3*COLOR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rdata)
    );

    logic              vld_in;
    logic [STAGES:1]   vld_pipe;
    logic              hl1, oor1;

    assign vld_in = run & pix_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            hl1      <= 1'b0;
            oor1     <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], vld_in};
            hl1      <= pix_hl;
            oor1     <= ~pix_ok;
        end
    end

    assign out_valid = vld_pipe[STAGES];

    rgb_t col1, col_out;
    logic key1;

    always_comb begin
        col1    = oor1 ? key_rgb() : rdata;
        key1    = (col1 == key_rgb());
        col_out = col1;
`ifdef SPRITE_PALETTE_HIGHLIGHT_EN
        // Halfway toward white; max-c never exceeds headroom so no carry out.
        if (hl1 && !key1) begin
            col_out.r = col1.r + ((CMAX - col1.r) >> 1);
            col_out.g = col1.g + ((CMAX - col1.g) >> 1);
            col_out.b = col1.b + ((CMAX - col1.b) >> 1);
        end
`endif
    end

`ifndef SPRITE_PALETTE_HIGHLIGHT_EN
    logic unused_hl;
    assign unused_hl = hl1 ^ (|CMAX);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            transparent <= 1'b0;
        end else if (vld_pipe[1]) begin
            red         <= col_out.r;
            green       <= col_out.g;
            blue        <= col_out.b;
            transparent <= key1;
        end
    end

endmodule

// File: doc/sprite_palette_lut.md
# sprite_palette_lut

Programmable multi-palette colour lookup for the chess board renderer. It replaces the per-piece fixed palette ROMs with one shared RAM that holds NUM_PAL palettes of 2^IDX_W entries each. Each entry is a 12-bit-class RGB colour. The block sits between the sprite ROM index fetch and the VGA colour mux. It adds a runtime write port, a self-initialising reset sequence, a 2-stage registered read pipeline with transparency detection, and optional square highlighting.

## Interface
- IDX_W, 4: colour index width; each palette has 2^IDX_W entries.
- NUM_PAL, 12: number of palettes, one per piece type.
- COLOR_W, 4: bits per colour channel. Constraint: COLOR_W >= IDX_W.
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel request valid.
- pix_pal  in  $clog2(NUM_PAL)  palette select.
- pix_idx  in  IDX_W  colour index.
- pix_hl  in  1  highlight request; used only with highlight compiled in.
- wr_en  in  1  palette entry write strobe.
- wr_pal  in  $clog2(NUM_PAL)  write palette select.
- wr_idx  in  IDX_W  write index.
- wr_rgb  in  3*COLOR_W  write colour, packed as {r,g,b}.
- init_done  out  1  high once the default palettes are loaded.
- out_valid  out  1  output pixel valid.
- red, green, blue  out  COLOR_W each  output colour.
- transparent  out  1  output colour equals the transparency key.

## Operation
- Transparency key KEY is {max, 0, max}, i.e. magenta (F,0,F at COLOR_W=4).
- State machine has two states: INIT and RUN.
- Reset forces the state to INIT and the entry counter to 0.
- INIT:
  - Writes one entry per cycle, walking palette-major from (0,0) to (NUM_PAL-1, 2^IDX_W-1).
  - Index 0 of every palette is written as KEY.
  - Index i>0 is written as grey: every channel = i << (COLOR_W-IDX_W).
  - After the last write, the state goes to RUN and init_done rises.
- RUN: this is the only state in which the write port and pixel requests are honoured.
- In INIT, wr_en and pix_valid are ignored and out_valid stays 0.
- Entries with pal >= NUM_PAL are out of range:
  - Writes to them are dropped.
  - Reads of them return KEY with transparent=1.
- Read/write collision on the same entry in the same cycle is write-first: the read returns wr_rgb.
- transparent = 1 exactly when the stored colour == KEY. The RGB outputs still carry KEY.
- Out-of-range and highlight handling do not alter pipeline latency.

## Timing
- Reset values:
  - init_done, out_valid and transparent = 0.
  - red, green and blue = 0.
  - State = INIT, counter = 0.
- INIT lasts NUM_PAL*2^IDX_W cycles after Reset deasserts; that is 192 cycles at the defaults.
- init_done is high in the first cycle after the final INIT write.
- Read latency is exactly 2 cycles, fully pipelined, with 1 pixel per cycle and no stalls:
  - Stage 1 registers the RAM data together with valid and hl.
  - Stage 2 registers the key compare, the highlight result and the outputs.
- A write in cycle N is visible to a read issued in cycle N or later.
- Reset asserted mid-INIT or mid-RUN:
  - Flushes both pipeline stages (out_valid=0 next cycle).
  - Restarts INIT from entry 0.
  - Discards any palette edits made before the reset.

## Configuration
- SPRITE_PALETTE_HIGHLIGHT_EN.
- Defined, for non-transparent pixels with pix_hl=1:
  - Each channel c becomes c + ((max - c) >> 1), i.e. halfway toward white.
  - The result is computed in COLOR_W bits and cannot overflow.
- Defined, transparent pixels: output unchanged regardless of pix_hl.
- Not defined: pix_hl is ignored, the stage-2 arithmetic is absent, and output = stored colour.
- Latency is 2 cycles either way.

## Structure
- Shared package sprite_pkg holds:
  - the state enum (INIT, RUN);
  - the KEY constant generator function;
  - the packed rgb_t struct;
  - the default-entry function (index -> grey/KEY).
- One sub-module, sprite_palette_ram:
  - simple dual-port RAM of depth NUM_PAL*2^IDX_W and width 3*COLOR_W;
  - one synchronous write port and one synchronous read port;
  - write-first bypass.
- The top level owns the INIT FSM, address mux, pipeline and highlight logic.

## Test plan
- Reset, then idle. Required response:
  - init_done rises exactly 192 cycles after Reset falls;
  - out_valid stays 0 throughout;
  - pix_valid during INIT produces no output.
- After INIT, read (pal 3, idx 0) and then (pal 3, idx 7). Required response, 2 cycles later each:
  - (F,0,F) with transparent=1;
  - then (7,7,7) with transparent=0.
- Write (pal 5, idx 2) = (A,3,C) in the same cycle as a read of (pal 5, idx 2). Required response: the output 2 cycles later is (A,3,C).
- With the macro defined, read (pal 0, idx 4) with pix_hl=1. Required response:
  - output (9,9,9);
  - the KEY entry with pix_hl=1 stays (F,0,F).
- Stream 20 back-to-back reads, then assert Reset mid-stream. Required response:
  - out_valid=0 on the next cycle;
  - earlier writes are reverted to the defaults after the new INIT.
- Read with pal=12 (out of range). Required response: (F,0,F) with transparent=1; writes to pal=12 leave the RAM unchanged.
